// File: rtl/mem_store_unit_pkg.sv
// Shared definitions for the store path: opcode/funct3 codes, FSM states
// and byte write-mask constants used by mem_store_unit and its lane aligner.
package mem_store_unit_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] FNC_SB = 3'b000;
    localparam logic [2:0] FNC_SH = 3'b001;
    localparam logic [2:0] FNC_SW = 3'b010;

    localparam logic [3:0] WMASK_NONE = 4'b0000;
    localparam logic [3:0] WMASK_B0   = 4'b0001;
    localparam logic [3:0] WMASK_LO   = 4'b0011;
    localparam logic [3:0] WMASK_HI   = 4'b1100;
    localparam logic [3:0] WMASK_ALL  = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } store_state_e;

    // True when funct3 names one of the three supported store widths.
    function automatic logic is_legal_store(input logic [2:0] funct3);
        return (funct3 == FNC_SB) || (funct3 == FNC_SH) || (funct3 == FNC_SW);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane aligner: replicates rs2 data across byte lanes,
// builds the byte write mask, and flags misaligned or illegal requests.
module store_lane_align
    import mem_store_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] wdata_o,
    output logic [3:0]      wmask_o,
    output logic            misaligned_o,
    output logic            illegal_o
);

    // Lane replication and mask generation per store width.
    always_comb begin
        wdata_o      = '0;
        wmask_o      = WMASK_NONE;
        misaligned_o = 1'b0;
        illegal_o    = !is_legal_store(funct3_i);
        unique case (funct3_i)
            FNC_SB: begin
                wdata_o = {4{data_i[7:0]}};
                wmask_o = WMASK_B0 << offset_i;
            end
            FNC_SH: begin
                wdata_o      = {2{data_i[15:0]}};
                wmask_o      = offset_i[1] ? WMASK_HI : WMASK_LO;
                misaligned_o = offset_i[0];
            end
            FNC_SW: begin
                wdata_o      = data_i;
                wmask_o      = WMASK_ALL;
                misaligned_o = (offset_i != 2'b00);
            end
            default: begin
                wdata_o = '0;
                wmask_o = WMASK_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mem_store_unit.sv
// Store unit between the EX/MEM register and the data-memory write port.
// Aligns store data, holds one request under valid/ready back-pressure,
// supports back-to-back issue, and counts completed stores.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned stores are dropped
// and reported on misalign_trap instead of being issued.
module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [2:0]       st_funct3,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_wmask,
    output logic             stall,
    output logic             store_done,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic             misalign_trap,
`endif
    output logic [CNT_W-1:0] store_cnt
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_MISALIGNED = 1'b1;
`else
    localparam bit TRAP_MISALIGNED = 1'b0;
`endif

    store_state_e      state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic [XLEN-1:0]   al_wdata;
    logic [3:0]        al_wmask;
    logic              al_misaligned;
    logic              al_illegal;

    logic              handshake;
    logic              accept;
    logic              issue;

    store_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3_i     (st_funct3),
        .offset_i     (st_addr[1:0]),
        .data_i       (st_data),
        .wdata_o      (al_wdata),
        .wmask_o      (al_wmask),
        .misaligned_o (al_misaligned),
        .illegal_o    (al_illegal)
    );

    // Handshake and accept qualifiers; the only paths from dmem_req_ready.
    always_comb begin
        st_ready  = (state_q == ST_IDLE) || ((state_q == ST_ISSUE) && dmem_req_ready);
        stall     = st_valid && !st_ready;
        handshake = (state_q == ST_ISSUE) && dmem_req_ready;
        accept    = st_valid && st_ready;
        issue     = accept && !al_illegal && !(TRAP_MISALIGNED && al_misaligned);
    end

    // Next-state and payload: a handshake retires the held request, and an
    // issuable accept in the same cycle reloads it so ISSUE is kept with no bubble.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        cnt_d   = cnt_q;
        done_d  = handshake || (accept && !issue);
        if (handshake) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (issue) begin
            state_d = ST_ISSUE;
            addr_d  = {st_addr[XLEN-1:2], 2'b00};
            wdata_d = al_wdata;
            wmask_d = al_wmask;
        end
    end

    // State, payload and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic trap_q;

    // Trap pulse one cycle after a misaligned legal store is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= accept && !al_illegal && al_misaligned;
        end
    end

    assign misalign_trap = trap_q;
`endif

    assign dmem_req_valid = (state_q == ST_ISSUE);
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wmask     = wmask_q;
    assign store_done     = done_q;
    assign store_cnt      = cnt_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_mem_store_unit;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        stall;
    logic        store_done;
    logic [15:0] store_cnt;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    mem_store_unit #(
        .XLEN  (32),
        .CNT_W (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_funct3      (st_funct3),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wmask     (dmem_wmask),
        .stall          (stall),
        .store_done     (store_done),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_trap  (misalign_trap),
`endif
        .store_cnt      (store_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: one outstanding memory write plus completion bookkeeping.
    bit          m_busy;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;
    int unsigned m_cnt;
    bit          m_done;
    bit          m_trap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Byte-lane image of a store: which bytes of the word it writes and with what.
    task automatic lane_image(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] wd, output logic [3:0] wm);
        int unsigned off;
        off = int'(a[1:0]);
        if (f == 3'd0) begin
            wd = {24'd0, d[7:0]} * 32'h0101_0101;
            wm = 4'(1 << off);
        end else if (f == 3'd1) begin
            wd = {16'd0, d[15:0]} * 32'h0001_0001;
            wm = (off >= 2) ? 4'hC : 4'h3;
        end else begin
            wd = d;
            wm = 4'hF;
        end
    endtask

    task automatic check_regs();
        check("req_valid", 32'(dmem_req_valid), 32'(m_busy));
        check("store_done", 32'(store_done), 32'(m_done));
        check("store_cnt", 32'(store_cnt), m_cnt % 65536);
        if (m_busy) begin
            check("dmem_addr", dmem_addr, m_addr);
            check("dmem_wdata", dmem_wdata, m_wdata);
            check("dmem_wmask", 32'(dmem_wmask), 32'(m_wmask));
        end
`ifdef MEM_MISALIGN_TRAP_EN
        check("misalign_trap", 32'(misalign_trap), 32'(m_trap));
`endif
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        st_valid = 1'b0;
        @(posedge clk);
        #1;
        m_busy = 0; m_done = 0; m_trap = 0; m_cnt = 0;
        check("rst_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_wmask", 32'(dmem_wmask), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_cnt", 32'(store_cnt), 32'd0);
        check("rst_done", 32'(store_done), 32'd0);
        check("rst_ready", 32'(st_ready), 32'd1);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst_trap", 32'(misalign_trap), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock of stimulus: entered and left at a falling edge.
    task automatic step(input logic v, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic r);
        bit exp_ready, hs, acc, legal, mis, drop;
        logic [31:0] wd;
        logic [3:0]  wm;
        st_valid = v; st_funct3 = f; st_addr = a; st_data = d; dmem_req_ready = r;
        #1;
        exp_ready = !m_busy || r;
        check("st_ready", 32'(st_ready), 32'(exp_ready));
        check("stall", 32'(stall), 32'(v && !exp_ready));
        hs    = m_busy && r;
        acc   = v && exp_ready;
        legal = (f <= 3'd2);
        mis   = (f == 3'd1 && a[0]) || (f == 3'd2 && a[1:0] != 2'b00);
        drop  = acc && (!legal || (TRAP_EN && mis));
        m_done = hs || drop;
        m_trap = TRAP_EN && acc && legal && mis;
        if (hs) begin
            m_cnt++;
            m_busy = 0;
        end
        if (acc && !drop) begin
            lane_image(f, a, d, wd, wm);
            m_busy  = 1;
            m_addr  = {a[31:2], 2'b00};
            m_wdata = wd;
            m_wmask = wm;
        end
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    initial begin
        st_valid = 0; st_funct3 = 0; st_addr = 0; st_data = 0; dmem_req_ready = 0;
        reset = 1;
        @(negedge clk);
        do_reset();

        // SB at offset 3: top lane only.
        step(1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 1);
        check("sb_addr", dmem_addr, 32'h0000_1000);
        check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
        check("sb_wmask", 32'(dmem_wmask), 32'h8);
        step(0, 3'd0, 32'd0, 32'd0, 1);
        check("sb_done", 32'(store_done), 32'd1);
        check("sb_cnt", 32'(store_cnt), 32'd1);

        // SH held under back-pressure while a second store waits.
        step(1, 3'd1, 32'h0000_2002, 32'h1234_5678, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 3'd2, 32'h0000_0040, 32'hCAFE_F00D, 0);
            check("sh_hold_wdata", dmem_wdata, 32'h5678_5678);
            check("sh_hold_wmask", 32'(dmem_wmask), 32'hC);
        end
        step(1, 3'd2, 32'h0000_0040, 32'hCAFE_F00D, 1);
        step(0, 3'd0, 32'd0, 32'd0, 1);

        // Back-to-back words, no bubble.
        step(1, 3'd2, 32'h0000_0010, 32'h1111_1111, 1);
        step(1, 3'd2, 32'h0000_0014, 32'h2222_2222, 1);
        check("b2b_valid", 32'(dmem_req_valid), 32'd1);
        step(0, 3'd0, 32'd0, 32'd0, 1);

        // Misaligned word, then illegal funct3.
        step(1, 3'd2, 32'h0000_3001, 32'h3333_3333, 1);
        step(0, 3'd0, 32'd0, 32'd0, 1);
        step(1, 3'd3, 32'h0000_4000, 32'h4444_4444, 1);
        step(0, 3'd0, 32'd0, 32'd0, 1);

        // Reset while a request is stuck in ISSUE.
        step(1, 3'd2, 32'h0000_0050, 32'h5555_5555, 0);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] f;
            f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), f, $urandom, $urandom,
                     1'($urandom_range(0, 2) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
